// File: rtl/mod_op_arbiter.sv
// Round-robin arbiter and sequencer sharing one mod_operation unit between NUM_REQ requesters.
// Optional unit watchdog compiled in with `define MODARB_TIMEOUT_EN.
`ifndef MAX_BITS
`define MAX_BITS 256
`endif

module mod_op_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int W              = `MAX_BITS,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_op,
    input  logic [NUM_REQ*W-1:0]       i_a,
    input  logic [NUM_REQ*W-1:0]       i_b,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic [NUM_REQ-1:0]         o_done,
    output logic [W-1:0]               o_result,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_owner,
    output logic                       o_error,
    output logic                       o_mul_start,
    output logic                       o_div_start,
    output logic [W-1:0]               o_a,
    output logic [W-1:0]               o_b,
    input  logic [W-1:0]               i_unit_result,
    input  logic                       i_unit_finished
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e             state_q;
    logic [OW-1:0]      rr_q;
    logic [OW-1:0]      owner_q;
    logic               op_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] done_q;
    logic [W-1:0]       result_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               busy_q;
    logic               mul_start_q;
    logic               div_start_q;

    logic [OW-1:0]      gnt_idx_d;
    logic               gnt_vld_d;
    logic [OW:0]        probe_d;

`ifdef MODARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0]      cnt_q;
    logic               err_q;
`endif

    // Scan from the highest rr offset down so the last hit is the one closest to the pointer.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_idx_d = '0;
        probe_d   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            probe_d = {1'b0, rr_q} + (OW+1)'(i);
            if (probe_d >= (OW+1)'(NUM_REQ)) begin
                probe_d = probe_d - (OW+1)'(NUM_REQ);
            end
            if (i_req[probe_d[OW-1:0]]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = probe_d[OW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            op_q        <= 1'b0;
            ack_q       <= '0;
            done_q      <= '0;
            result_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
`ifdef MODARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            ack_q       <= '0;
            done_q      <= '0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
`ifdef MODARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        owner_q            <= gnt_idx_d;
                        op_q               <= i_op[gnt_idx_d];
                        a_q                <= i_a[int'(gnt_idx_d)*W +: W];
                        b_q                <= i_b[int'(gnt_idx_d)*W +: W];
                        ack_q[gnt_idx_d]   <= 1'b1;
                        busy_q             <= 1'b1;
                        state_q            <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_start_q <= ~op_q;
                    div_start_q <= op_q;
`ifdef MODARB_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                    state_q     <= S_WAIT;
                end
                // Operands stay on a_q/b_q: the unit re-reads them on its second multiply pass.
                S_WAIT: begin
                    if (i_unit_finished) begin
                        result_q        <= i_unit_result;
                        done_q[owner_q] <= 1'b1;
                        state_q         <= S_RESP;
                    end
`ifdef MODARB_TIMEOUT_EN
                    else if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
                        result_q        <= '0;
                        err_q           <= 1'b1;
                        done_q[owner_q] <= 1'b1;
                        state_q         <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (owner_q == OW'(NUM_REQ - 1)) begin
                        rr_q <= '0;
                    end else begin
                        rr_q <= owner_q + 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ack       = ack_q;
    assign o_done      = done_q;
    assign o_result    = result_q;
    assign o_busy      = busy_q;
    assign o_owner     = owner_q;
    assign o_mul_start = mul_start_q;
    assign o_div_start = div_start_q;
    assign o_a         = a_q;
    assign o_b         = b_q;
`ifdef MODARB_TIMEOUT_EN
    assign o_error     = err_q;
`else
    assign o_error     = 1'b0;
`endif

endmodule
